neuron_accumulator: RTL and testbench



---
 rtl/neuron_accumulator.sv | 171 +++++++++++++++++
 tb/tb_neuron_accumulator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/neuron_accumulator.sv
// Post-adder stage: saturating accumulation of signed tree sums, then rounding shift,
// activation and output clip. Define RELU_ACT_EN for ReLU activation (default: linear).
module neuron_accumulator #(
   parameter int SUM_BITS = 9,
   parameter int ACC_BITS = 16,
   parameter int N_CHUNKS = 4,
   parameter int SHIFT    = 2,
   parameter int OUT_BITS = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [SUM_BITS-1:0] in_sum,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [OUT_BITS-1:0] out_act,
   output logic                       out_sat,
   output logic                       out_err
);

   localparam int CNT_W   = $clog2(N_CHUNKS + 1);
   localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CHUNKS - 1);

   localparam logic signed [ACC_BITS:0] ACC_MAX = {2'b00, {(ACC_BITS-1){1'b1}}};
   localparam logic signed [ACC_BITS:0] ACC_MIN = {2'b11, {(ACC_BITS-1){1'b0}}};
   localparam logic signed [ACC_BITS:0] RND     =
      (SHIFT > 0) ? ((ACC_BITS+1)'(1) << RND_POS) : '0;
   localparam logic signed [ACC_BITS:0] OUT_MAX =
      {{(ACC_BITS-OUT_BITS+2){1'b0}}, {(OUT_BITS-1){1'b1}}};
`ifdef RELU_ACT_EN
   // ReLU floor at zero is not a saturation event; only the upper clip is.
   localparam logic signed [ACC_BITS:0] ACT_LO = '0;
`else
   localparam logic signed [ACC_BITS:0] ACT_LO =
      {{(ACC_BITS-OUT_BITS+2){1'b1}}, {(OUT_BITS-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      ST_ACC = 2'd0,
      ST_ACT = 2'd1,
      ST_OUT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic signed [ACC_BITS-1:0] acc_p0;
   logic [CNT_W-1:0]           cnt_q;
   logic                       sat_q;
   logic                       err_q;
   logic signed [ACC_BITS:0]   sum_p0;
   logic signed [ACC_BITS:0]   r_p1;
   logic                       accept;
   logic                       final_chunk;
   logic                       handshake;

   function automatic logic acc_ovf(input logic signed [ACC_BITS:0] x);
      return (x > ACC_MAX) || (x < ACC_MIN);
   endfunction

   function automatic logic signed [ACC_BITS-1:0] acc_clip(input logic signed [ACC_BITS:0] x);
      if (x > ACC_MAX)
         return ACC_MAX[ACC_BITS-1:0];
      else if (x < ACC_MIN)
         return ACC_MIN[ACC_BITS-1:0];
      else
         return x[ACC_BITS-1:0];
   endfunction

   // Half-up rounding; one guard bit keeps acc + RND from wrapping.
   function automatic logic signed [ACC_BITS:0] round_shift(input logic signed [ACC_BITS-1:0] a);
      logic signed [ACC_BITS:0] t;
      t = (ACC_BITS+1)'(a) + RND;
      return t >>> SHIFT;
   endfunction

   function automatic logic act_ovf(input logic signed [ACC_BITS:0] r);
`ifdef RELU_ACT_EN
      return r > OUT_MAX;
`else
      return (r > OUT_MAX) || (r < ACT_LO);
`endif
   endfunction

   function automatic logic signed [OUT_BITS-1:0] act_clip(input logic signed [ACC_BITS:0] r);
      if (r > OUT_MAX)
         return OUT_MAX[OUT_BITS-1:0];
      else if (r < ACT_LO)
         return ACT_LO[OUT_BITS-1:0];
      else
         return r[OUT_BITS-1:0];
   endfunction

   assign sum_p0 = (ACC_BITS+1)'(acc_p0) + (ACC_BITS+1)'(in_sum);
   assign r_p1   = round_shift(acc_p0);

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      final_chunk = 1'b0;
      handshake   = 1'b0;
      case (state_q)
         ST_ACC: begin
            accept      = in_valid && in_ready;
            final_chunk = accept && (in_last || (cnt_q == LAST_CNT));
            if (final_chunk)
               state_d = ST_ACT;
         end
         ST_ACT: state_d = ST_OUT;
         ST_OUT: begin
            handshake = out_ready;
            if (out_ready)
               state_d = ST_ACC;
         end
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ACC;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_ready  <= (state_d == ST_ACC);
         out_valid <= (state_d == ST_OUT);
      end
   end

   // Stage p0: accumulate accepted chunks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_p0 <= '0;
         cnt_q  <= '0;
         sat_q  <= 1'b0;
         err_q  <= 1'b0;
      end else if (accept) begin
         acc_p0 <= acc_clip(sum_p0);
         cnt_q  <= cnt_q + CNT_W'(1);
         sat_q  <= sat_q | acc_ovf(sum_p0);
         err_q  <= final_chunk && !in_last;
      end else if (handshake) begin
         acc_p0 <= '0;
         cnt_q  <= '0;
         sat_q  <= 1'b0;
         err_q  <= 1'b0;
      end
   end

   // Stage p1: requantize and activate, held until the consumer takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_act <= '0;
         out_sat <= 1'b0;
         out_err <= 1'b0;
      end else if (state_q == ST_ACT) begin
         out_act <= act_clip(r_p1);
         out_sat <= sat_q | act_ovf(r_p1);
         out_err <= err_q;
      end else if (handshake) begin
         out_act <= '0;
         out_sat <= 1'b0;
         out_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Randomized bench for neuron_accumulator; a wide (16b) and a narrow (10b) accumulator
// instance share stimulus and are each compared to an integer reference model.
module tb_neuron_accumulator;

   localparam int SUM_BITS = 9;
   localparam int SHIFT    = 2;
   localparam int OUT_BITS = 4;
   localparam int NCH      = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_last = 1'b0;
   logic out_ready = 1'b0;
   logic signed [SUM_BITS-1:0] in_sum = '0;

   logic in_ready, out_valid, out_sat, out_err;
   logic signed [OUT_BITS-1:0] out_act;
   logic nr_in_ready, nr_out_valid, nr_out_sat, nr_out_err;
   logic signed [OUT_BITS-1:0] nr_out_act;

   int checks = 0;
   int failures = 0;
   int cur[NCH];

   always #5 clk = ~clk;

   neuron_accumulator #(.SUM_BITS(SUM_BITS), .ACC_BITS(16), .N_CHUNKS(NCH),
                        .SHIFT(SHIFT), .OUT_BITS(OUT_BITS)) u_wide (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_act(out_act), .out_sat(out_sat), .out_err(out_err));

   neuron_accumulator #(.SUM_BITS(SUM_BITS), .ACC_BITS(10), .N_CHUNKS(NCH),
                        .SHIFT(SHIFT), .OUT_BITS(OUT_BITS)) u_narrow (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nr_in_ready),
      .in_sum(in_sum), .in_last(in_last), .out_valid(nr_out_valid),
      .out_ready(out_ready), .out_act(nr_out_act), .out_sat(nr_out_sat),
      .out_err(nr_out_err));

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: integer accumulate with clamp, floor((acc + half) / 2^SHIFT), activation clamp.
   task automatic model(input int abits, input int n, output int act, output bit sat);
      longint acc, amax, amin, x, d, r, omax, omin;
      acc  = 0;
      sat  = 1'b0;
      amax = (longint'(1) << (abits - 1)) - 1;
      amin = -(longint'(1) << (abits - 1));
      for (int i = 0; i < n; i++) begin
         acc = acc + cur[i];
         if (acc > amax) begin acc = amax; sat = 1'b1; end
         else if (acc < amin) begin acc = amin; sat = 1'b1; end
      end
      d = longint'(1) << SHIFT;
      x = acc + d / 2;
      r = x / d;
      if ((x % d != 0) && (x < 0)) r = r - 1;
      omax = (longint'(1) << (OUT_BITS - 1)) - 1;
      omin = -(longint'(1) << (OUT_BITS - 1));
`ifdef RELU_ACT_EN
      if (r < 0) r = 0;
      if (r > omax) begin r = omax; sat = 1'b1; end
`else
      if (r > omax) begin r = omax; sat = 1'b1; end
      else if (r < omin) begin r = omin; sat = 1'b1; end
`endif
      act = int'(r);
   endtask

   task automatic check_reset_vals();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_act", out_act, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_nr_in_ready", nr_in_ready, 1);
      chk("rst_nr_out_valid", nr_out_valid, 0);
      chk("rst_nr_out_sat", nr_out_sat, 0);
   endtask

   task automatic send_chunks(input int n, input bit last);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("acc_in_ready", in_ready, 1);
         in_valid = 1'b1;
         in_sum   = SUM_BITS'(cur[i]);
         in_last  = last && (i == n - 1);
         @(posedge clk);
         #1;
      end
   endtask

   // Runs one neuron from ACC through OUT; optionally resets while the result is held.
   task automatic run_neuron(input int n, input bit last, input bit hold,
                             input int stall, input bit rst_out);
      int act_w, act_n;
      bit sat_w, sat_n;
      send_chunks(n, last);
      in_valid = hold;
      in_sum   = SUM_BITS'($urandom_range(0, 511));
      in_last  = 1'($urandom_range(0, 1));
      model(16, n, act_w, sat_w);
      model(10, n, act_n, sat_n);
      @(negedge clk);
      chk("act_out_valid", out_valid, 0);
      chk("act_in_ready", in_ready, 0);
      @(negedge clk);
      for (int s = 0; s <= stall; s++) begin
         chk("out_valid", out_valid, 1);
         chk("out_in_ready", in_ready, 0);
         chk("out_act", longint'(out_act), act_w);
         chk("out_sat", out_sat, sat_w);
         chk("out_err", out_err, !last);
         chk("nr_out_valid", nr_out_valid, 1);
         chk("nr_out_act", longint'(nr_out_act), act_n);
         chk("nr_out_sat", nr_out_sat, sat_n);
         chk("nr_out_err", nr_out_err, !last);
         if (s < stall) @(negedge clk);
      end
      in_valid = 1'b0;
      if (rst_out) begin
         #1 rst_n = 1'b0;
         #1 check_reset_vals();
         @(negedge clk);
         rst_n = 1'b1;
      end else begin
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
         @(negedge clk);
         chk("post_hs_out_valid", out_valid, 0);
         chk("post_hs_in_ready", in_ready, 1);
         chk("post_hs_nr_in_ready", nr_in_ready, 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_reset_vals();
      rst_n = 1'b1;

      cur[0] = 10; cur[1] = 5;
      run_neuron(2, 1'b1, 1'b0, 0, 1'b0);
      cur[0] = -20;
      run_neuron(1, 1'b1, 1'b0, 0, 1'b0);
      for (int i = 0; i < NCH; i++) cur[i] = 255;
      run_neuron(4, 1'b1, 1'b0, 0, 1'b0);
      for (int i = 0; i < NCH; i++) cur[i] = 1;
      run_neuron(4, 1'b0, 1'b1, 2, 1'b0);
      cur[0] = 10; cur[1] = 5;
      run_neuron(2, 1'b1, 1'b1, 5, 1'b0);

      // Reset mid-accumulation: partial sum must be discarded.
      cur[0] = 100; cur[1] = 100;
      send_chunks(2, 1'b0);
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      cur[0] = 3;
      run_neuron(1, 1'b1, 1'b0, 0, 1'b0);

      for (int i = 0; i < NCH; i++) cur[i] = 255;
      run_neuron(4, 1'b1, 1'b0, 1, 1'b1);
      cur[0] = 6;
      run_neuron(1, 1'b1, 1'b0, 0, 1'b0);

      for (int k = 0; k < 150; k++) begin
         int n;
         bit last;
         n    = $urandom_range(1, NCH);
         last = (n < NCH) ? 1'b1 : 1'($urandom_range(0, 1));
         for (int i = 0; i < NCH; i++) cur[i] = int'($urandom_range(0, 511)) - 256;
         run_neuron(n, last, 1'($urandom_range(0, 1)), $urandom_range(0, 5), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
